// File: rtl/elevator_car_ctrl.sv
// 8-floor elevator car controller: call latching, SCAN scheduling, floor stepping and door dwell.
// Optional emergency stop input is compiled in with `define ELEV_ESTOP_EN.
module elevator_car_ctrl #(
    parameter int TRAVEL_CYCLES = 50,
    parameter int DOOR_CYCLES   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] call_req,
    output logic [2:0] floornum,
    output logic       state,
    output logic       moving,
    output logic       door_open,
    output logic [7:0] pending
`ifdef ELEV_ESTOP_EN
    ,
    input  logic       estop
`endif
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MOVING     = 2'd1,
        DOORS_OPEN = 2'd2
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    floor_q, floor_d;
    logic          dir_q, dir_d;
    logic [7:0]    pending_q, pending_d;
    logic          moving_q, door_q;
    logic          hold_w;

`ifdef ELEV_ESTOP_EN
    assign hold_w = estop;
`else
    assign hold_w = 1'b0;
`endif

    logic [7:0] above_w, below_w, door_mask_w;
    logic       ahead_w, behind_w;

    for (genvar gi = 0; gi < 8; gi++) begin : g_dir_masks
        assign above_w[gi] = pending_q[gi] && (3'(gi) > floor_q);
        assign below_w[gi] = pending_q[gi] && (3'(gi) < floor_q);
    end

    assign ahead_w     = dir_q ? |below_w : |above_w;
    assign behind_w    = dir_q ? |above_w : |below_w;
    // A call for the open floor only extends the dwell, so it is masked from the latch.
    assign door_mask_w = (fsm_q == DOORS_OPEN) ? (8'd1 << floor_q) : 8'd0;

    always_comb begin
        fsm_d     = fsm_q;
        timer_d   = timer_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        pending_d = pending_q | (call_req & ~door_mask_w);
        if (!hold_w) begin
            case (fsm_q)
                IDLE: begin
                    if (pending_q[floor_q]) begin
                        fsm_d              = DOORS_OPEN;
                        timer_d            = DOOR_LOAD;
                        pending_d[floor_q] = 1'b0;
                    end else if (ahead_w) begin
                        fsm_d   = MOVING;
                        timer_d = TRAVEL_LOAD;
                    end else if (behind_w) begin
                        fsm_d   = MOVING;
                        timer_d = TRAVEL_LOAD;
                        dir_d   = ~dir_q;
                    end
                end
                MOVING: begin
                    if (timer_q == '0) begin
                        floor_d = dir_q ? floor_q - 3'd1 : floor_q + 3'd1;
                        if (pending_q[floor_d]) begin
                            fsm_d              = DOORS_OPEN;
                            timer_d            = DOOR_LOAD;
                            pending_d[floor_d] = 1'b0;
                        end else begin
                            timer_d = TRAVEL_LOAD;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                DOORS_OPEN: begin
                    if (call_req[floor_q]) begin
                        timer_d = DOOR_LOAD;
                    end else if (timer_q == '0) begin
                        fsm_d = IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            timer_q   <= '0;
            floor_q   <= 3'd0;
            dir_q     <= 1'b0;
            pending_q <= 8'd0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            timer_q   <= timer_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            moving_q  <= (fsm_d == MOVING) && !hold_w;
            door_q    <= (fsm_d == DOORS_OPEN);
        end
    end

    assign floornum  = floor_q;
    assign state     = dir_q;
    assign moving    = moving_q;
    assign door_open = door_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_car_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] call_req = 8'd0;
    logic [2:0] floornum;
    logic       state;
    logic       moving;
    logic       door_open;
    logic [7:0] pending;
`ifdef ELEV_ESTOP_EN
    logic       estop = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    elevator_car_ctrl #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .call_req(call_req),
        .floornum(floornum),
        .state(state),
        .moving(moving),
        .door_open(door_open),
        .pending(pending)
`ifdef ELEV_ESTOP_EN
        ,
        .estop(estop)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] f, input logic s,
                           input logic m, input logic d, input logic [7:0] p);
        chk({tag, ".floor"}, {5'd0, floornum}, {5'd0, f});
        chk({tag, ".state"}, {7'd0, state}, {7'd0, s});
        chk({tag, ".moving"}, {7'd0, moving}, {7'd0, m});
        chk({tag, ".door"}, {7'd0, door_open}, {7'd0, d});
        chk({tag, ".pending"}, pending, p);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1 chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk_all("idle0", 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Single call to floor 3
        call_req = 8'h08;
        tick();                                   // E0
        call_req = 8'h00;
        chk_all("e0", 3'd0, 1'b0, 1'b0, 1'b0, 8'h08);
        tick();                                   // E0+1
        chk_all("depart", 3'd0, 1'b0, 1'b1, 1'b0, 8'h08);
        tick(3);                                  // E0+4
        chk("pre_f1", {5'd0, floornum}, 8'd0);
        tick();                                   // E0+5
        chk_all("f1", 3'd1, 1'b0, 1'b1, 1'b0, 8'h08);
        tick(4);                                  // E0+9
        chk_all("f2", 3'd2, 1'b0, 1'b1, 1'b0, 8'h08);
        tick(4);                                  // E0+13
        chk_all("arr3", 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
        tick(2);                                  // E0+15
        chk("dwell3", {7'd0, door_open}, 8'd1);
        tick();                                   // E0+16
        chk_all("close3", 3'd3, 1'b0, 1'b0, 1'b0, 8'h00);

        // SCAN: calls at 1 and 7 from floor 3 heading up
        call_req = 8'h82;
        tick();                                   // F0
        call_req = 8'h00;
        chk("scan_latch", pending, 8'h82);
        tick();                                   // F0+1
        chk_all("scan_dep", 3'd3, 1'b0, 1'b1, 1'b0, 8'h82);
        tick(16);                                 // F0+17
        chk_all("arr7", 3'd7, 1'b0, 1'b0, 1'b1, 8'h02);
        tick(3);                                  // F0+20
        chk_all("idle7", 3'd7, 1'b0, 1'b0, 1'b0, 8'h02);
        tick();                                   // F0+21
        chk_all("reverse", 3'd7, 1'b1, 1'b1, 1'b0, 8'h02);
        tick(23);                                 // F0+44
        chk_all("pre_arr1", 3'd2, 1'b1, 1'b1, 1'b0, 8'h02);
        tick();                                   // F0+45
        chk_all("arr1", 3'd1, 1'b1, 1'b0, 1'b1, 8'h00);

        // Door extend: call for floor 1 held two cycles during dwell
        call_req = 8'h02;
        tick(2);                                  // F0+47
        call_req = 8'h00;
        chk_all("ext_hold", 3'd1, 1'b1, 1'b0, 1'b1, 8'h00);
        tick(2);                                  // F0+49
        chk_all("ext_last", 3'd1, 1'b1, 1'b0, 1'b1, 8'h00);
        tick();                                   // F0+50
        chk_all("ext_close", 3'd1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        chk_all("ext_idle", 3'd1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Idle at current floor (floor 0 after reset)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        call_req = 8'h01;
        tick();                                   // G0
        call_req = 8'h00;
        chk_all("g0", 3'd0, 1'b0, 1'b0, 1'b0, 8'h01);
        tick();                                   // G0+1
        chk_all("door0", 3'd0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick(2);
        chk_all("dwell0", 3'd0, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk_all("close0", 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset mid-travel at floor 5
        call_req = 8'h80;
        tick();                                   // H0
        call_req = 8'h00;
        tick(22);                                 // H0+22
        chk_all("mid5", 3'd5, 1'b0, 1'b1, 1'b0, 8'h80);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("post_rst", 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef ELEV_ESTOP_EN
        // Emergency stop for 10 edges while travelling to floor 2
        call_req = 8'h04;
        tick();                                   // J0
        call_req = 8'h00;
        tick(3);                                  // J0+3
        chk("es_pre", {7'd0, moving}, 8'd1);
        estop = 1'b1;
        call_req = 8'h40;
        tick();                                   // J0+4
        call_req = 8'h00;
        chk_all("es_on", 3'd0, 1'b0, 1'b0, 1'b0, 8'h44);
        tick(9);                                  // J0+13
        chk_all("es_hold", 3'd0, 1'b0, 1'b0, 1'b0, 8'h44);
        estop = 1'b0;
        tick();                                   // J0+14
        chk_all("es_rel", 3'd0, 1'b0, 1'b1, 1'b0, 8'h44);
        tick();                                   // J0+15
        chk("es_f1", {5'd0, floornum}, 8'd1);
        tick(3);                                  // J0+18
        chk_all("es_pre2", 3'd1, 1'b0, 1'b1, 1'b0, 8'h44);
        tick();                                   // J0+19
        chk_all("es_arr2", 3'd2, 1'b0, 1'b0, 1'b1, 8'h40);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elevator_car_ctrl.md
# elevator_car_ctrl

Car-motion controller for the 8-floor elevator. It latches hall/car call buttons and schedules them with a collective (SCAN) policy. It steps the car one floor at a time and times door dwell. It is the producer side of the display path: its `floornum` and `state` outputs drive the 7-segment floor/direction decoder directly, with the same encoding (floor 0–7 binary; `state` 0 = up, 1 = down).

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 50: clock cycles to travel one floor; must be ≥ 1.
- `DOOR_CYCLES`, default 100: clock cycles the door stays open; must be ≥ 1.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `call_req` input 8: one bit per floor, level or pulse; sampled every rising edge.
- `floornum` output 3: current (last reached) floor.
- `state` output 1: travel direction, 0 = up, 1 = down.
- `moving` output 1: car is between floors.
- `door_open` output 1: door open at `floornum`.
- `pending` output 8: latched, unserved calls.
- `estop` input 1: emergency stop. Present only with `ELEV_ESTOP_EN`.

## Operation
- All outputs are registered. Reset value of every output is 0: floor 0, direction up, door closed, no pending calls; FSM in IDLE.
- Call latch: `pending[i]` is set at the edge where `call_req[i]`=1, with one exception. While in DOORS_OPEN, a call for `floornum` is not latched; it reloads the door timer instead.
- Call clear: `pending[i]` clears at the edge that enters DOORS_OPEN at floor i. A same-edge set and clear for that floor resolves to clear.
- "Ahead" means any pending bit strictly above `floornum` when `state`=0, or strictly below when `state`=1.
- IDLE:
  - If `pending[floornum]` is set, go to DOORS_OPEN.
  - Else, if calls are ahead, go to MOVING and keep `state`.
  - Else, if calls exist in the opposite direction, toggle `state` and go to MOVING.
  - Else, stay in IDLE.
- MOVING:
  - Timer loads `TRAVEL_CYCLES`-1 on entry and decrements each cycle.
  - At the edge where the timer is 0, `floornum` ±1 (+1 for up).
  - If `pending` is set at the new floor, go to DOORS_OPEN. Else stay in MOVING and reload the timer.
- DOORS_OPEN: timer loads `DOOR_CYCLES`-1. When it reaches 0, go to IDLE.
- Boundaries: the car moves only toward a pending call, so `floornum` never wraps past 7 or below 0. An illegal wrap is a verification error.
- Reset mid-travel or mid-dwell returns the car to floor 0 immediately. All pending calls are lost.
- `moving`=1 exactly in MOVING; `door_open`=1 exactly in DOORS_OPEN.

## Timing
- Call latch latency: 1 edge from `call_req` to `pending`.
- Departure: with a call latched at edge E0 and the FSM in IDLE, `moving` rises at E0+1.
- Arrival one floor away: `floornum` updates, `moving` falls and `door_open` rises together at E0+1+`TRAVEL_CYCLES`.
- N floors away: arrival at E0+1+N·`TRAVEL_CYCLES`, with no idle cycles at intermediate floors.
- Door dwell: `door_open` is high for exactly `DOOR_CYCLES` cycles. An in-door call at the current floor extends it to `DOOR_CYCLES` cycles after that call.
- After the door closes, there is one IDLE cycle before the next departure or door reopen.
- Call at the current floor while idle: `door_open` rises at E0+1; no movement.

## Configuration
- `ELEV_ESTOP_EN` defined:
  - Port `estop` exists.
  - While `estop`=1, the FSM state, both timers, `floornum` and `state` hold their values, and `moving` is forced to 0.
  - `pending` continues to latch calls.
  - On release, operation resumes with the remaining timer count.
- `ELEV_ESTOP_EN` undefined: no `estop` port; behaviour is identical to `estop` tied to 0.

## Test plan
Run with `TRAVEL_CYCLES`=4 and `DOOR_CYCLES`=3.
- Single call: after reset, pulse `call_req`=8'h08 → `moving` rises 1 edge later; `floornum` steps 1, 2, 3 every 4 cycles; `door_open` is high 3 cycles at floor 3; `pending` returns to 0.
- SCAN ordering: at floor 3 moving up, latch calls 8'h82 (floors 1 and 7) → serves floor 7 first, then reverses (`state`=1) and serves floor 1.
- Door extend: hold `call_req[floornum]` for 2 cycles during dwell → `door_open` is high 3 cycles past the last request cycle; `pending` stays 0.
- Idle at current floor: idle at floor 0, `call_req`=8'h01 → `door_open` high next edge; `floornum`=0 and `moving`=0 throughout.
- Reset mid-travel: assert `rst_n`=0 asynchronously while `moving`=1 at floor 5 → all outputs 0 immediately, without waiting for an edge.
- `ELEV_ESTOP_EN`: raise `estop` for 10 cycles mid-travel → `floornum` frozen, `moving`=0; after release, arrival occurs 10 cycles later than nominal; a call made during the stop appears in `pending`.
